tristate_bus_arbiter: RTL and testbench

//  Sequential owner-select for a shared tri-state line built from bufif1/notif1 cells.

---
 rtl/tristate_arb_pkg.sv | 14 +
 rtl/tristate_bus_arbiter_if.sv | 16 +
 rtl/tristate_bus_arbiter_rr_pick.sv | 29 ++
 rtl/tristate_bus_arbiter.sv | 110 +++++++++++
 tb/tb_tristate_bus_arbiter.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/tristate_arb_pkg.sv
// Shared types and helpers for the tri-state bus arbiter.
// Holds the FSM state encoding and the round-robin pointer increment.
package tristate_arb_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, TURN} arb_state_t;

    localparam int N_MAX = 16;
    localparam int IDX_W = $clog2(N_MAX);

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] ptr, input int unsigned n);
        return (32'(ptr) + 32'd1 >= n) ? '0 : ptr + 1'b1;
    endfunction

endpackage

// File: rtl/tristate_bus_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
// One grant bit per bufif1 control pin.
interface tristate_bus_arbiter_if #(
    parameter int N = 4
);
    localparam int IDW = $clog2(N);

    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic           bus_busy;
    logic [IDW-1:0] owner_id;

    modport master (output req, input grant, input bus_busy, input owner_id);
    modport slave  (input req, output grant, output bus_busy, output owner_id);

endinterface

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping mod N.
// Produces a onehot0 pick vector and the index of the picked bit.
module tristate_bus_arbiter_rr_pick #(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] rr_ptr,
    output logic [N-1:0]   pick,
    output logic [IDW-1:0] pick_idx
);

    always_comb begin
        logic [IDW-1:0] idx;
        pick     = '0;
        pick_idx = '0;
        idx      = '0;
        // Scan farthest-first so the candidate closest to rr_ptr overwrites the rest.
        for (int i = N - 1; i >= 0; i--) begin
            idx = IDW'((32'(rr_ptr) + 32'(i)) % N);
            if (req[idx]) begin
                pick      = '0;
                pick[idx] = 1'b1;
                pick_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner-select for a shared tri-state line; grant[i] enables requester i's bufif1.
// Define ARB_TURNAROUND_EN to insert a one-cycle floating gap (state TURN) between owners.
module tristate_bus_arbiter
    import tristate_arb_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 8,
    localparam int IDW      = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    tristate_bus_arbiter_if.slave bus
);

    localparam int             HW        = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(MAX_HOLD - 1);

    arb_state_t     state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic           bus_busy_q, bus_busy_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [HW-1:0]  hold_q, hold_d;

    logic [N-1:0]   pick;
    logic [IDW-1:0] pick_idx, pick_ptr, owner_next;
    logic           release_now;

    assign owner_next  = IDW'(rr_next(IDX_W'(owner_q), N));
    assign release_now = (state_q == GRANT) &&
                         (!bus.req[owner_q] ||
                          (hold_q == HOLD_LAST && (bus.req & ~grant_q) != '0));
    // A release arbitrates against the pointer it is about to write, not the stale one.
    assign pick_ptr    = (state_q == GRANT) ? owner_next : rr_ptr_q;

    tristate_bus_arbiter_rr_pick #(.N(N)) u_rr_pick (
        .req      (bus.req),
        .rr_ptr   (pick_ptr),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        hold_d   = hold_q;
        unique case (state_q)
            GRANT: begin
                if (release_now) begin
                    rr_ptr_d = owner_next;
`ifdef ARB_TURNAROUND_EN
                    state_d = TURN;
                    grant_d = '0;
`else
                    if (pick != '0) begin
                        state_d = GRANT;
                        grant_d = pick;
                        owner_d = pick_idx;
                        hold_d  = '0;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
`endif
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                if (pick != '0) begin
                    state_d = GRANT;
                    grant_d = pick;
                    owner_d = pick_idx;
                    hold_d  = '0;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
        endcase
        bus_busy_d = |grant_d;
    end

    // NOTE: state is written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            bus_busy_q <= 1'b0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            bus_busy_q <= bus_busy_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_q     <= hold_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.bus_busy = bus_busy_q;
    assign bus.owner_id = owner_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed vector table plus multi-cycle sequences and a random invariant sweep
// for tristate_bus_arbiter (N=4, MAX_HOLD=8), with or without ARB_TURNAROUND_EN.
module tb_tristate_bus_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;
    localparam int LIMIT    = (N - 1) * (MAX_HOLD + 1);

    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        logic       busy;
        logic [1:0] owner;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    tristate_bus_arbiter_if #(.N(N)) bus_if ();

    tristate_bus_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got no summary by time %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic [3:0] r);
        @(negedge clk);
        bus_if.req = r;
        @(posedge clk);
        #1;
    endtask

    // Tri-state line model: each granted requester drives its own data bit.
    function automatic logic resolve(input logic [3:0] en, input logic [3:0] data);
        logic v;
        v = 1'bz;
        for (int i = 0; i < 4; i++) begin
            if (en[i]) begin
                if (v === 1'bz) v = data[i];
                else if (v !== data[i]) v = 1'bx;
            end
        end
        return v;
    endfunction

    vec_t       vecs [18];
    logic [3:0] exp_g;
    logic [3:0] r;
    logic [3:0] drv_data;
    logic       bus_val;
    int         wait_cnt [4];
    int         worst;
    int         dur;
    int         cyc;

    initial begin
        vecs[0]  = '{4'b0010, 4'b0010, 1'b1, 2'd1};
        vecs[1]  = '{4'b0010, 4'b0010, 1'b1, 2'd1};
        vecs[2]  = '{4'b0000, 4'b0000, 1'b0, 2'd0};
        vecs[3]  = '{4'b0011, 4'b0001, 1'b1, 2'd0};
        vecs[4]  = '{4'b0000, 4'b0000, 1'b0, 2'd0};
        vecs[5]  = '{4'b1100, 4'b0100, 1'b1, 2'd2};
        vecs[6]  = '{4'b0000, 4'b0000, 1'b0, 2'd0};
        vecs[7]  = '{4'b0101, 4'b0001, 1'b1, 2'd0};
        vecs[8]  = '{4'b0000, 4'b0000, 1'b0, 2'd0};
        vecs[9]  = '{4'b1000, 4'b1000, 1'b1, 2'd3};
        vecs[10] = '{4'b0000, 4'b0000, 1'b0, 2'd0};
        vecs[11] = '{4'b1001, 4'b0001, 1'b1, 2'd0};
        vecs[12] = '{4'b0000, 4'b0000, 1'b0, 2'd0};
        vecs[13] = '{4'b0001, 4'b0001, 1'b1, 2'd0};
        vecs[14] = '{4'b0101, 4'b0001, 1'b1, 2'd0};
        vecs[15] = '{4'b0001, 4'b0001, 1'b1, 2'd0};
        vecs[16] = '{4'b0000, 4'b0000, 1'b0, 2'd0};
        vecs[17] = '{4'b0000, 4'b0000, 1'b0, 2'd0};
        drv_data = 4'b0101;

        rst        = 1'b1;
        bus_if.req = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset grant", bus_if.grant, 4'b0000);
        check("reset busy", bus_if.bus_busy, 1'b0);
        check("reset owner", bus_if.owner_id, 2'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            tick(vecs[i].req);
            check($sformatf("vec%0d grant", i), bus_if.grant, vecs[i].grant);
            check($sformatf("vec%0d busy", i), bus_if.bus_busy, vecs[i].busy);
            if (vecs[i].busy) check($sformatf("vec%0d owner", i), bus_if.owner_id, vecs[i].owner);
        end

        // Reset asserted mid-grant must drop the enable before the next edge.
        tick(4'b0100);
        check("pre-reset grant", bus_if.grant, 4'b0100);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async reset grant", bus_if.grant, 4'b0000);
        check("async reset busy", bus_if.bus_busy, 1'b0);
        bus_if.req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;

        // All four requesting: owners 0,1,2,3,0 for exactly MAX_HOLD cycles each.
        for (int t = 0; t < 5; t++) begin
            exp_g = 4'b0001 << (t % 4);
            for (int c = 0; c < MAX_HOLD; c++) begin
                tick(4'b1111);
                check($sformatf("rr turn%0d cycle%0d", t, c), bus_if.grant, exp_g);
            end
`ifdef ARB_TURNAROUND_EN
            if (t < 4) begin
                tick(4'b1111);
                check($sformatf("rr gap%0d", t), bus_if.grant, 4'b0000);
            end
`endif
        end
        tick(4'b0000);
        check("rr release", bus_if.grant, 4'b0000);

        // Lone requester keeps the bus well past MAX_HOLD.
        for (int c = 0; c < 50; c++) begin
            tick(4'b0001);
            check($sformatf("hold cycle%0d", c), bus_if.grant, 4'b0001);
        end

        // Owner 3 hits the hold limit with req=1001: pointer wraps to 0.
        tick(4'b0000);
        check("wrap idle", bus_if.grant, 4'b0000);
        tick(4'b1000);
        check("wrap owner3", bus_if.grant, 4'b1000);
        for (int c = 0; c < MAX_HOLD - 1; c++) begin
            tick(4'b1001);
            check($sformatf("wrap hold%0d", c), bus_if.grant, 4'b1000);
        end
        tick(4'b1001);
`ifdef ARB_TURNAROUND_EN
        check("wrap gap", bus_if.grant, 4'b0000);
        tick(4'b1001);
`endif
        check("wrap next grant", bus_if.grant, 4'b0001);
        check("wrap next owner", bus_if.owner_id, 2'd0);

        tick(4'b0000);
        tick(4'b0000);
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        cyc = 0;
        while (cyc < 3000) begin
            r   = 4'($urandom_range(0, 15));
            dur = $urandom_range(1, 20);
            for (int k = 0; k < dur && cyc < 3000; k++) begin
                tick(r);
                cyc++;
                bus_val = resolve(bus_if.grant, drv_data);
                check("onehot0", $onehot0(bus_if.grant), 1'b1);
                check("busy", bus_if.bus_busy, |bus_if.grant);
                if (bus_if.bus_busy) check("owner", bus_if.grant, 4'b0001 << bus_if.owner_id);
                check("bus no x", bus_val === 1'bx, 1'b0);
                worst = 0;
                for (int i = 0; i < 4; i++) begin
                    if (r[i] && !bus_if.grant[i]) wait_cnt[i]++;
                    else wait_cnt[i] = 0;
                    if (wait_cnt[i] > worst) worst = wait_cnt[i];
                end
                check("starvation", worst <= LIMIT, 1'b1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
